// File: rtl/alarm_ctrl.sv
// Time-of-day keeper (h:m:s from a 1 Hz tick) with alarm ring/snooze sequencer and BCD outputs.
// Optional feature: define ALARM_SNOOZE_EN to build the SNOOZE state and the snooze input.
module alarm_ctrl #(
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned MAX_SNOOZE = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       alarm_en,
  input  logic [5:0] limit_hour,
  input  logic [5:0] limit_min,
  input  logic       ack,
  input  logic       snooze,
  output logic       ringing,
  output logic       buzz,
  output logic       snoozing,
  output logic [3:0] hour1,
  output logic [3:0] hour2,
  output logic [3:0] min1,
  output logic [3:0] min2,
  output logic [3:0] sec1,
  output logic [3:0] sec2
);

  typedef enum logic [1:0] {StIdle, StRing, StSnooze} state_e;

  localparam logic [7:0] RingInit = 8'(RING_SEC);

  state_e     state_q, state_d;
  logic [5:0] sec_q, min_q, hour_q, sec_d, min_d, hour_d;
  logic [7:0] ring_cnt_q, ring_cnt_d;
  logic       buzz_q, buzz_d;
  logic       match;

`ifdef ALARM_SNOOZE_EN
  localparam logic [9:0] SnzInit = 10'(SNOOZE_MIN * 60);
  localparam logic [2:0] MaxSnz  = 3'(MAX_SNOOZE);
  logic [9:0] snz_cnt_q, snz_cnt_d;
  logic [2:0] snz_num_q, snz_num_d;
`else
  logic unused_cfg;
  assign unused_cfg = snooze ^ (SNOOZE_MIN > 0) ^ (MAX_SNOOZE > 0);
`endif

  always_comb begin
    sec_d  = sec_q;
    min_d  = min_q;
    hour_d = hour_q;
    if (tick_1hz) begin
      if (sec_q == 6'd59) begin
        sec_d = 6'd0;
        if (min_q == 6'd59) begin
          min_d  = 6'd0;
          hour_d = (hour_q == 6'd23) ? 6'd0 : hour_q + 6'd1;
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end
  end

  // Compare against the time being entered, so the match fires once on the tick into hh:mm:00.
  // Out-of-range limits can never equal an in-range next time.
  assign match = tick_1hz & alarm_en & (sec_d == 6'd0) & (min_d == limit_min) &
                 (hour_d == limit_hour);

  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    buzz_d     = buzz_q;
`ifdef ALARM_SNOOZE_EN
    snz_cnt_d  = snz_cnt_q;
    snz_num_d  = snz_num_q;
`endif
    if (!alarm_en) begin
      state_d    = StIdle;
      ring_cnt_d = 8'd0;
      buzz_d     = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (match) begin
            state_d    = StRing;
            ring_cnt_d = RingInit;
            buzz_d     = 1'b1;
`ifdef ALARM_SNOOZE_EN
            snz_num_d  = 3'd0;
`endif
          end
        end
        StRing: begin
          if (ack) begin
            state_d    = StIdle;
            ring_cnt_d = 8'd0;
            buzz_d     = 1'b0;
          end
`ifdef ALARM_SNOOZE_EN
          else if (snooze && (snz_num_q < MaxSnz)) begin
            state_d    = StSnooze;
            snz_cnt_d  = SnzInit;
            snz_num_d  = snz_num_q + 3'd1;
            ring_cnt_d = 8'd0;
            buzz_d     = 1'b0;
          end
`endif
          else if (tick_1hz) begin
            if (ring_cnt_q <= 8'd1) begin
              state_d    = StIdle;
              ring_cnt_d = 8'd0;
              buzz_d     = 1'b0;
            end else begin
              ring_cnt_d = ring_cnt_q - 8'd1;
              buzz_d     = ~buzz_q;
            end
          end
        end
`ifdef ALARM_SNOOZE_EN
        StSnooze: begin
          if (ack) begin
            state_d   = StIdle;
            snz_cnt_d = 10'd0;
          end else if (tick_1hz) begin
            if (snz_cnt_q <= 10'd1) begin
              state_d    = StRing;
              snz_cnt_d  = 10'd0;
              ring_cnt_d = RingInit;
              buzz_d     = 1'b1;
            end else begin
              snz_cnt_d = snz_cnt_q - 10'd1;
            end
          end
        end
`endif
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      sec_q      <= 6'd0;
      min_q      <= 6'd0;
      hour_q     <= 6'd0;
      ring_cnt_q <= 8'd0;
      buzz_q     <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      snz_cnt_q  <= 10'd0;
      snz_num_q  <= 3'd0;
`endif
    end else begin
      state_q    <= state_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hour_q     <= hour_d;
      ring_cnt_q <= ring_cnt_d;
      buzz_q     <= buzz_d;
`ifdef ALARM_SNOOZE_EN
      snz_cnt_q  <= snz_cnt_d;
      snz_num_q  <= snz_num_d;
`endif
    end
  end

  assign ringing = (state_q == StRing);
  assign buzz    = ringing & buzz_q;
`ifdef ALARM_SNOOZE_EN
  assign snoozing = (state_q == StSnooze);
`else
  assign snoozing = 1'b0;
`endif

  assign hour1 = 4'(hour_q / 6'd10);
  assign hour2 = 4'(hour_q % 6'd10);
  assign min1  = 4'(min_q / 6'd10);
  assign min2  = 4'(min_q % 6'd10);
  assign sec1  = 4'(sec_q / 6'd10);
  assign sec2  = 4'(sec_q % 6'd10);

endmodule

// File: tb/tb_alarm_ctrl.sv
// Scoreboard bench for alarm_ctrl: seconds-of-day reference model, randomized stimulus,
// monitor compares every cycle's outputs against the queued expectation.
module tb_alarm_ctrl;

  localparam int unsigned RingSec   = 60;
  localparam int unsigned SnoozeMin = 5;
  localparam int unsigned MaxSnooze = 3;
`ifdef ALARM_SNOOZE_EN
  localparam bit SnzEn = 1'b1;
`else
  localparam bit SnzEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       alarm_en = 1'b0;
  logic [5:0] limit_hour = '0;
  logic [5:0] limit_min = '0;
  logic       ack = 1'b0;
  logic       snooze = 1'b0;
  logic       ringing, buzz, snoozing;
  logic [3:0] hour1, hour2, min1, min2, sec1, sec2;

  always #5 clk = ~clk;

  alarm_ctrl #(
    .RING_SEC  (RingSec),
    .SNOOZE_MIN(SnoozeMin),
    .MAX_SNOOZE(MaxSnooze)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_1hz  (tick_1hz),
    .alarm_en  (alarm_en),
    .limit_hour(limit_hour),
    .limit_min (limit_min),
    .ack       (ack),
    .snooze    (snooze),
    .ringing   (ringing),
    .buzz      (buzz),
    .snoozing  (snoozing),
    .hour1     (hour1),
    .hour2     (hour2),
    .min1      (min1),
    .min2      (min2),
    .sec1      (sec1),
    .sec2      (sec2)
  );

  int checks = 0;
  int errors = 0;
  logic [26:0] exp_q[$];

  // Reference model: time as seconds since midnight; mode 0 idle, 1 ring, 2 snooze.
  int m_t, m_mode, m_ring_left, m_snz_left, m_snz_used;
  bit m_bz;

  function automatic logic [26:0] model_out();
    int h, m, s;
    h = m_t / 3600;
    m = (m_t / 60) % 60;
    s = m_t % 60;
    return {m_mode == 1, (m_mode == 1) && m_bz, m_mode == 2,
            4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic model_reset();
    m_t = 0; m_mode = 0; m_ring_left = 0; m_snz_left = 0; m_snz_used = 0; m_bz = 1'b0;
  endtask

  task automatic model_step(input bit tk, input bit ak, input bit sz, input bit en,
                            input int lh, input int lm);
    int  nt;
    bit  hit;
    nt  = tk ? (m_t + 1) % 86400 : m_t;
    hit = tk && en && lh < 24 && lm < 60 && nt == lh * 3600 + lm * 60;
    if (!en) m_mode = 0;
    else if (m_mode == 0) begin
      if (hit) begin
        m_mode = 1; m_ring_left = RingSec; m_snz_used = 0; m_bz = 1'b1;
      end
    end else if (m_mode == 1) begin
      if (ak) m_mode = 0;
      else if (SnzEn && sz && m_snz_used < MaxSnooze) begin
        m_mode = 2; m_snz_left = SnoozeMin * 60; m_snz_used++;
      end else if (tk) begin
        m_ring_left--;
        m_bz = !m_bz;
        if (m_ring_left == 0) m_mode = 0;
      end
    end else begin
      if (ak) m_mode = 0;
      else if (tk) begin
        m_snz_left--;
        if (m_snz_left == 0) begin
          m_mode = 1; m_ring_left = RingSec; m_bz = 1'b1;
        end
      end
    end
    m_t = nt;
  endtask

  task automatic check(input logic [26:0] exp, input string name);
    logic [26:0] got;
    got = {ringing, buzz, snoozing, hour1, hour2, min1, min2, sec1, sec2};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got ring/buzz/snz=%b%b%b time=%h%h:%h%h:%h%h, expected %b%b%b %h%h:%h%h:%h%h",
               name, $time, got[26], got[25], got[24], got[23:20], got[19:16], got[15:12],
               got[11:8], got[7:4], got[3:0], exp[26], exp[25], exp[24], exp[23:20],
               exp[19:16], exp[15:12], exp[11:8], exp[7:4], exp[3:0]);
    end
  endtask

  // Drive one cycle's inputs, advance the model, queue what the DUT must show after the edge.
  task automatic step(input bit rs, input bit tk, input bit ak, input bit sz, input bit en,
                      input int lh, input int lm);
    @(negedge clk);
    rst_n = rs; tick_1hz = tk; ack = ak; snooze = sz; alarm_en = en;
    limit_hour = 6'(lh); limit_min = 6'(lm);
    if (!rs) model_reset();
    else model_step(tk, ak, sz, en, lh, lm);
    exp_q.push_back(model_out());
  endtask

  initial begin
    logic [26:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e, "scoreboard");
      end
    end
  end

  initial begin
    int lh, lm, tgt;
    bit tk, ak, sz, en, found;
    model_reset();
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 2);

    // Continuous ticks: ring at 00:02:00 for 60 s, time reaches past 01:01:01.
    for (int i = 0; i < 4000; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0, 2);

    // Random traffic with limits re-aimed a few minutes ahead, sometimes out of range.
    lh = 0; lm = 0;
    for (int i = 0; i < 30000; i++) begin
      if (i % 600 == 0) begin
        tgt = ((m_t / 60) + $urandom_range(1, 4)) * 60;
        lh  = (tgt / 3600) % 24;
        lm  = (tgt / 60) % 60;
        if ($urandom_range(7) == 0) begin
          if ($urandom_range(1) == 0) lh = $urandom_range(24, 63);
          else lm = $urandom_range(60, 63);
        end
      end
      tk = ($urandom_range(7) != 0);
      ak = ($urandom_range(399) == 0);
      sz = ($urandom_range(39) == 0);
      en = ($urandom_range(2999) != 0);
      if (m_mode == 1 && $urandom_range(149) == 0) begin
        ak = 1'b1; sz = 1'b1;
      end
      if (m_mode == 2 && $urandom_range(499) == 0) en = 1'b0;
      step(1'b1, tk, ak, sz, en, lh, lm);
    end

    // Reset asserted in the middle of a ring.
    tgt = ((m_t / 60) + 1) * 60;
    lh = (tgt / 3600) % 24;
    lm = (tgt / 60) % 60;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, lh, lm);
      found = (m_mode == 1);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL ring_wait: model never reached ring within 200 cycles, required ring");
    end
    repeat (10) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, lh, lm);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check(model_out(), "async_reset_mid_ring");
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0);

    // Limit 00:00 right after reset must not ring at t=0.
    for (int i = 0; i < 1000; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0);

    repeat (3) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
